// File: rtl/draw_scheduler.sv
// Tile-redraw sequencer feeding a single sprite_draw engine.
// Arbitrates between a full-board scan and a FIFO of dirty-tile requests; one draw in flight.
module draw_scheduler #(
  parameter int unsigned BOARD_W    = 20,
  parameter int unsigned BOARD_H    = 15,
  parameter int unsigned TILE       = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_full_redraw_req,
  input  logic       i_dirty_valid,
  input  logic [4:0] i_dirty_col,
  input  logic [3:0] i_dirty_row,
  output logic       o_dirty_ready,
  output logic [8:0] o_map_rd_addr,
  input  logic [2:0] i_map_rd_data,
  output logic       o_draw_start,
  output logic [7:0] o_x_out,
  output logic [6:0] o_y_out,
  output logic [2:0] o_sprite_id_out,
  input  logic       i_draw_done,
  output logic       o_busy,
  output logic       o_scan_done,
  output logic       o_oob_drop
);

  localparam int unsigned COL_W  = 5;
  localparam int unsigned ROW_W  = 4;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned X_W    = 8;
  localparam int unsigned Y_W    = 7;
  localparam int unsigned SPR_W  = 3;
  localparam int unsigned ENT_W  = COL_W + ROW_W;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t              r_state;
  logic                r_scanning;
  logic                r_scan_pending;
  logic [COL_W-1:0]    r_cur_col;
  logic [ROW_W-1:0]    r_cur_row;
  logic [ADDR_W-1:0]   r_map_rd_addr;
  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_y;
  logic [SPR_W-1:0]    r_sprite;
  logic                r_draw_start;
  logic                r_scan_done;
  logic                r_oob_drop;

  logic [ENT_W-1:0]    r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr;
  logic [PTR_W-1:0]    r_rd;
  logic [CNT_W-1:0]    r_count;

  logic                w_push;
  logic                w_pop;
  logic                w_fifo_empty;
  logic [ENT_W-1:0]    w_head;
  logic [COL_W-1:0]    w_head_col;
  logic [ROW_W-1:0]    w_head_row;
  logic                w_avail;
  logic                w_head_oob;
  logic                w_decide;
  logic                w_pend;
  logic                w_last_col;
  logic                w_last;
  logic                w_mid_scan;
  logic                w_advance;
  logic                w_start_scan;
  logic                w_take;
  logic                w_go_fetch;
  logic [COL_W-1:0]    w_tgt_col;
  logic [ROW_W-1:0]    w_tgt_row;
  logic [ADDR_W-1:0]   w_tgt_addr;
  logic [X_W-1:0]      w_tgt_x;
  logic [Y_W-1:0]      w_tgt_y;

  // Source selection; an empty FIFO forwards a same-cycle push straight to the head.
  always_comb begin
    w_push       = i_dirty_valid && (r_count != CNT_W'(FIFO_DEPTH));
    w_fifo_empty = (r_count == '0);
    w_head       = w_fifo_empty ? {i_dirty_row, i_dirty_col} : r_fifo[r_rd];
    w_head_col   = w_head[COL_W-1:0];
    w_head_row   = w_head[ENT_W-1:COL_W];
    w_avail      = !w_fifo_empty || w_push;
    w_head_oob   = (32'(w_head_col) >= BOARD_W) || (32'(w_head_row) >= BOARD_H);
    w_decide     = (r_state == S_IDLE) || ((r_state == S_WAIT) && i_draw_done);
    w_pend       = r_scan_pending || i_full_redraw_req;
    w_last_col   = (r_cur_col == COL_W'(BOARD_W - 1));
    w_last       = r_scanning && w_last_col && (r_cur_row == ROW_W'(BOARD_H - 1));
    w_mid_scan   = r_scanning && !w_last;
    w_advance    = w_decide && w_mid_scan && !w_pend;
    w_start_scan = w_decide && w_pend;
    w_take       = w_decide && !w_pend && !w_mid_scan && w_avail;
    w_pop        = w_take;
    w_go_fetch   = w_advance || w_start_scan || (w_take && !w_head_oob);

    w_tgt_col = w_head_col;
    w_tgt_row = w_head_row;
    if (w_start_scan) begin
      w_tgt_col = '0;
      w_tgt_row = '0;
    end else if (w_advance) begin
      w_tgt_col = w_last_col ? '0 : (r_cur_col + COL_W'(1));
      w_tgt_row = w_last_col ? (r_cur_row + ROW_W'(1)) : r_cur_row;
    end
    w_tgt_addr = ADDR_W'(32'(w_tgt_row) * BOARD_W + 32'(w_tgt_col));
    w_tgt_x    = X_W'(32'(w_tgt_col) * TILE);
    w_tgt_y    = Y_W'(32'(w_tgt_row) * TILE);
  end

  // Dirty FIFO pointers; a redraw request discards everything queued before it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_full_redraw_req) begin
      r_rd    <= r_wr;
      r_wr    <= w_push ? (r_wr + PTR_W'(1)) : r_wr;
      r_count <= w_push ? CNT_W'(1) : '0;
    end else begin
      if (w_push) r_wr <= r_wr + PTR_W'(1);
      if (w_pop)  r_rd <= r_rd + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[r_wr] <= {i_dirty_row, i_dirty_col};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_scanning     <= 1'b0;
      r_scan_pending <= 1'b0;
      r_cur_col      <= '0;
      r_cur_row      <= '0;
      r_map_rd_addr  <= '0;
      r_x            <= '0;
      r_y            <= '0;
      r_sprite       <= '0;
      r_draw_start   <= 1'b0;
      r_scan_done    <= 1'b0;
      r_oob_drop     <= 1'b0;
    end else begin
      r_draw_start <= 1'b0;
      r_scan_done  <= 1'b0;
      r_oob_drop   <= 1'b0;
      if (w_start_scan)           r_scan_pending <= 1'b0;
      else if (i_full_redraw_req) r_scan_pending <= 1'b1;

      case (r_state)
        S_IDLE, S_WAIT: begin
          if (w_decide) begin
            r_scan_done <= w_last;
            r_oob_drop  <= w_take && w_head_oob;
            if (w_start_scan)    r_scanning <= 1'b1;
            else if (!w_advance) r_scanning <= 1'b0;
            if (w_go_fetch) begin
              r_state       <= S_FETCH;
              r_cur_col     <= w_tgt_col;
              r_cur_row     <= w_tgt_row;
              r_map_rd_addr <= w_tgt_addr;
              r_x           <= w_tgt_x;
              r_y           <= w_tgt_y;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_FETCH: r_state <= S_LATCH;
        S_LATCH: begin
          r_sprite     <= i_map_rd_data;
          r_draw_start <= 1'b1;
          r_state      <= S_ISSUE;
        end
        S_ISSUE: r_state <= S_WAIT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_dirty_ready   = (r_count != CNT_W'(FIFO_DEPTH));
  assign o_map_rd_addr   = r_map_rd_addr;
  assign o_draw_start    = r_draw_start;
  assign o_x_out         = r_x;
  assign o_y_out         = r_y;
  assign o_sprite_id_out = r_sprite;
  assign o_busy          = (r_state != S_IDLE) || (r_count != '0) || r_scan_pending;
  assign o_scan_done     = r_scan_done;
  assign o_oob_drop      = r_oob_drop;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: registered map RAM model and a sprite_draw responder
// that returns draw_done a programmable number of cycles after each draw_start.
module tb_draw_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       full_redraw_req = 1'b0;
  logic       dirty_valid = 1'b0;
  logic [4:0] dirty_col = '0;
  logic [3:0] dirty_row = '0;
  logic       dirty_ready;
  logic [8:0] map_rd_addr;
  logic [2:0] map_rd_data = '0;
  logic       draw_start;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] sprite_id_out;
  logic       draw_done;
  logic       busy;
  logic       scan_done;
  logic       oob_drop;

  int checks = 0;
  int failures = 0;
  int dly = 2;
  bit hold = 1'b0;
  int pend = 0;
  int n_scan_done = 0;
  int n_oob = 0;
  logic [17:0] log_q [$];

  always #5 clk = ~clk;

  draw_scheduler dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_full_redraw_req (full_redraw_req),
    .i_dirty_valid     (dirty_valid),
    .i_dirty_col       (dirty_col),
    .i_dirty_row       (dirty_row),
    .o_dirty_ready     (dirty_ready),
    .o_map_rd_addr     (map_rd_addr),
    .i_map_rd_data     (map_rd_data),
    .o_draw_start      (draw_start),
    .o_x_out           (x_out),
    .o_y_out           (y_out),
    .o_sprite_id_out   (sprite_id_out),
    .i_draw_done       (draw_done),
    .o_busy            (busy),
    .o_scan_done       (scan_done),
    .o_oob_drop        (oob_drop)
  );

  function automatic logic [2:0] spr_of(input int a);
    return 3'(a + 2);
  endfunction

  function automatic int ent(input int c, input int r);
    logic [17:0] e;
    e = {8'(c * 8), 7'(r * 8), spr_of(r * 20 + c)};
    return int'(e);
  endfunction

  function automatic int get(input int i);
    if (i < log_q.size()) return int'(log_q[i]);
    return -1;
  endfunction

  // Map RAM: data valid one cycle after the address.
  always @(posedge clk) map_rd_data <= spr_of(int'(map_rd_addr));

  // sprite_draw responder and event logger.
  initial begin
    draw_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      draw_done = 1'b0;
      if (!hold && pend > 0) begin
        pend = pend - 1;
        if (pend == 0) draw_done = 1'b1;
      end
      if (draw_start) begin
        log_q.push_back({x_out, y_out, sprite_id_out});
        pend = dly;
      end
      if (scan_done) n_scan_done = n_scan_done + 1;
      if (oob_drop)  n_oob = n_oob + 1;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int c, input int r);
    dirty_valid = 1'b1;
    dirty_col   = 5'(c);
    dirty_row   = 4'(r);
    @(negedge clk);
    dirty_valid = 1'b0;
  endtask

  task automatic pulse_req();
    full_redraw_req = 1'b1;
    @(negedge clk);
    full_redraw_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  task automatic chk_scan(input int base, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (get(base + i) != ent(i % 20, i / 20)) bad++;
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    int base;
    int sbase;
    int obase;
    int n;
    int e;

    repeat (2) @(negedge clk);
    chk("rst_draw_start", int'(draw_start), 0);
    chk("rst_scan_done", int'(scan_done), 0);
    chk("rst_oob_drop", int'(oob_drop), 0);
    chk("rst_x", int'(x_out), 0);
    chk("rst_y", int'(y_out), 0);
    chk("rst_sprite", int'(sprite_id_out), 0);
    chk("rst_addr", int'(map_rd_addr), 0);
    chk("rst_dirty_ready", int'(dirty_ready), 1);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;
    @(negedge clk);

    // Single dirty push, latency and hold.
    dly = 10;
    base = log_q.size();
    push(3, 2);
    chk("t2_addr", int'(map_rd_addr), 43);
    chk("t2_fetch_nostart", int'(draw_start), 0);
    @(negedge clk);
    chk("t2_latch_nostart", int'(draw_start), 0);
    @(negedge clk);
    chk("t2_draw_start", int'(draw_start), 1);
    chk("t2_x", int'(x_out), 24);
    chk("t2_y", int'(y_out), 16);
    chk("t2_sprite", int'(sprite_id_out), 5);
    @(negedge clk);
    chk("t2_start_pulse", int'(draw_start), 0);
    repeat (4) @(negedge clk);
    chk("t2_hold_x", int'(x_out), 24);
    chk("t2_busy_wait", int'(busy), 1);
    wait_idle(20, "t2");
    chk("t2_draws", log_q.size() - base, 1);

    // Full scan.
    dly = 2;
    base = log_q.size();
    sbase = n_scan_done;
    pulse_req();
    wait_idle(2500, "t3");
    chk("t3_count", log_q.size() - base, 300);
    chk_scan(base, "t3_order");
    e = get(base + 299);
    chk("t3_last", e, ent(19, 14));
    chk("t3_last_x", (e >> 10) & 255, 152);
    chk("t3_last_y", (e >> 3) & 127, 112);
    chk("t3_scan_done", n_scan_done - sbase, 1);

    // FIFO fill while the engine is stalled.
    hold = 1'b1;
    base = log_q.size();
    push(1, 1);
    repeat (4) @(negedge clk);
    push(2, 1);
    push(3, 1);
    push(4, 1);
    chk("t4_ready_3", int'(dirty_ready), 1);
    push(5, 1);
    chk("t4_ready_full", int'(dirty_ready), 0);
    push(6, 1);
    chk("t4_ready_still", int'(dirty_ready), 0);
    hold = 1'b0;
    wait_idle(200, "t4");
    chk("t4_count", log_q.size() - base, 5);
    n = 0;
    for (int i = 0; i < 5; i++) if (get(base + i) != ent(i + 1, 1)) n++;
    chk("t4_order", n, 0);

    // Redraw request flushes queued entries.
    hold = 1'b1;
    base = log_q.size();
    sbase = n_scan_done;
    push(7, 7);
    repeat (4) @(negedge clk);
    push(1, 0);
    push(2, 0);
    push(3, 0);
    pulse_req();
    hold = 1'b0;
    wait_idle(2500, "t5a");
    chk("t5a_count", log_q.size() - base, 301);
    chk("t5a_first", get(base), ent(7, 7));
    chk_scan(base + 1, "t5a_order");
    chk("t5a_scan_done", n_scan_done - sbase, 1);

    // Push in the request cycle survives the flush.
    hold = 1'b1;
    base = log_q.size();
    sbase = n_scan_done;
    push(7, 7);
    repeat (4) @(negedge clk);
    push(1, 0);
    push(2, 0);
    full_redraw_req = 1'b1;
    dirty_valid = 1'b1;
    dirty_col = 5'd9;
    dirty_row = 4'd3;
    @(negedge clk);
    full_redraw_req = 1'b0;
    dirty_valid = 1'b0;
    hold = 1'b0;
    wait_idle(2500, "t5b");
    chk("t5b_count", log_q.size() - base, 302);
    chk_scan(base + 1, "t5b_order");
    chk("t5b_tail", get(base + 301), ent(9, 3));
    chk("t5b_scan_done", n_scan_done - sbase, 1);

    // Out-of-range entries are dropped.
    base = log_q.size();
    obase = n_oob;
    push(25, 0);
    repeat (3) @(negedge clk);
    chk("t6_oob", n_oob - obase, 1);
    chk("t6_nodraw", log_q.size() - base, 0);
    chk("t6_busy", int'(busy), 0);
    hold = 1'b1;
    push(4, 4);
    repeat (4) @(negedge clk);
    push(0, 15);
    push(5, 5);
    hold = 1'b0;
    wait_idle(200, "t6q");
    chk("t6q_oob", n_oob - obase, 2);
    chk("t6q_count", log_q.size() - base, 2);
    chk("t6q_second", get(base + 1), ent(5, 5));

    // Redraw request mid-scan restarts after the current tile.
    base = log_q.size();
    sbase = n_scan_done;
    pulse_req();
    n = 0;
    while ((log_q.size() - base) < 101 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("t6b_reach", log_q.size() - base, 101);
    pulse_req();
    wait_idle(2500, "t6b");
    chk("t6b_count", log_q.size() - base, 401);
    chk("t6b_tile100", get(base + 100), ent(0, 5));
    chk_scan(base + 101, "t6b_restart_order");
    chk("t6b_scan_done", n_scan_done - sbase, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
